// File: rtl/slap_match_ctrl.sv
// Round/match controller for the two-player hand-slap game: stroke animation,
// collision, dodge penalties, hold screens and win/restart, all outputs registered.
module slap_match_ctrl #(
  parameter int X_W        = 8,
  parameter int SCORE_W    = 4,
  parameter int PEN_W      = 2,
  parameter int WIN_SCORE  = 5,
  parameter int PEN_LIMIT  = 3,
  parameter int TRAVEL     = 29,
  parameter int HOLD_TICKS = 350,
  parameter int P1_HOME    = 35,
  parameter int P2_HOME    = 61
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tick,
  input  logic               btn_p1,
  input  logic               btn_p2,
  input  logic               btn_restart,
  output logic [X_W-1:0]     p1_x,
  output logic [X_W-1:0]     p2_x,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [PEN_W-1:0]   p1_pen,
  output logic [PEN_W-1:0]   p2_pen,
  output logic               attacker,
  output logic [2:0]         screen,
  output logic               controls_en
);

  localparam int CW = $clog2(TRAVEL + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [1:0] S_IDLE = 2'd0, S_OUT = 2'd1, S_BACK = 2'd2;
  localparam logic [1:0] M_PLAY = 2'd0, M_HOLD = 2'd1, M_WIN = 2'd2;
  localparam logic [2:0] SCR_PLAY = 3'd0, SCR_HIT_P1 = 3'd1, SCR_HIT_P2 = 3'd2,
                         SCR_FREE_P1 = 3'd3, SCR_FREE_P2 = 3'd4,
                         SCR_WIN_P1 = 3'd5, SCR_WIN_P2 = 3'd6;

  logic [1:0]         mode;
  logic [1:0]         stroke  [2];
  logic [CW-1:0]      cnt     [2];
  logic               fwd     [2];  // 1: hand moves +1 during OUT, -1 during BACK
  logic [X_W-1:0]     hand_x  [2];
  logic [SCORE_W-1:0] score   [2];
  logic [PEN_W-1:0]   pen     [2];
  logic [HW-1:0]      hold_cnt;
  logic               opening;

  logic [1:0] btn;
  logic [1:0] turn;
  logic       hit_now, miss_now, pen_now;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(WIN_SCORE)) ? s : s + 1'b1;
  endfunction

  assign btn = {btn_p2, btn_p1};

  always_comb begin
    for (int i = 0; i < 2; i++)
      turn[i] = tick && (stroke[i] == S_OUT) && (cnt[i] == CW'(TRAVEL - 1));
    hit_now  = (stroke[attacker] == S_OUT) && (hand_x[0] >= hand_x[1]);
    miss_now = turn[attacker];
    pen_now  = turn[~attacker] && (stroke[attacker] == S_IDLE);
  end

  // NOTE: every state element, arrays included, uses non-blocking assignment so
  // each branch below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode        <= M_PLAY;
      screen      <= SCR_PLAY;
      controls_en <= 1'b1;
      attacker    <= 1'b0;
      opening     <= 1'b0;
      hold_cnt    <= '0;
      for (int i = 0; i < 2; i++) begin
        stroke[i] <= S_IDLE;
        cnt[i]    <= '0;
        fwd[i]    <= 1'b0;
        score[i]  <= '0;
        pen[i]    <= '0;
      end
      hand_x[0] <= X_W'(P1_HOME);
      hand_x[1] <= X_W'(P2_HOME);
    end else begin
      case (mode)
        M_PLAY: begin
          if (hit_now) begin
            score[attacker] <= sat_inc(score[attacker]);
            screen          <= attacker ? SCR_HIT_P2 : SCR_HIT_P1;
            mode            <= M_HOLD;
            controls_en     <= 1'b0;
            hold_cnt        <= '0;
          end else begin
            for (int i = 0; i < 2; i++) begin
              if (stroke[i] == S_IDLE) begin
                if (btn[i]) begin
                  stroke[i] <= S_OUT;
                  cnt[i]    <= '0;
                  // Both hands head +1 when P1 attacks: P1 toward, P2 away.
                  fwd[i]    <= ~attacker;
                end
              end else if (tick) begin
                if ((stroke[i] == S_OUT) == fwd[i]) hand_x[i] <= hand_x[i] + X_W'(1);
                else                                hand_x[i] <= hand_x[i] - X_W'(1);
                if (cnt[i] == CW'(TRAVEL - 1)) begin
                  cnt[i]    <= '0;
                  stroke[i] <= (stroke[i] == S_OUT) ? S_BACK : S_IDLE;
                end else begin
                  cnt[i] <= cnt[i] + 1'b1;
                end
              end
            end
            if (miss_now) begin
              attacker <= ~attacker;
              pen[0]   <= '0;
              pen[1]   <= '0;
            end else if (pen_now) begin
              pen[~attacker] <= pen[~attacker] + 1'b1;
              if (pen[~attacker] == PEN_W'(PEN_LIMIT - 1)) begin
                score[attacker] <= sat_inc(score[attacker]);
                screen          <= attacker ? SCR_FREE_P2 : SCR_FREE_P1;
                mode            <= M_HOLD;
                controls_en     <= 1'b0;
                hold_cnt        <= '0;
              end
            end
          end
        end
        M_HOLD: begin
          if (tick) begin
            if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
              for (int i = 0; i < 2; i++) begin
                stroke[i] <= S_IDLE;
                cnt[i]    <= '0;
                pen[i]    <= '0;
              end
              hand_x[0] <= X_W'(P1_HOME);
              hand_x[1] <= X_W'(P2_HOME);
              if (score[0] == SCORE_W'(WIN_SCORE)) begin
                screen <= SCR_WIN_P1;
                mode   <= M_WIN;
              end else if (score[1] == SCORE_W'(WIN_SCORE)) begin
                screen <= SCR_WIN_P2;
                mode   <= M_WIN;
              end else begin
                screen      <= SCR_PLAY;
                mode        <= M_PLAY;
                controls_en <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        M_WIN: begin
          if (btn_restart) begin
            for (int i = 0; i < 2; i++) begin
              score[i] <= '0;
              pen[i]   <= '0;
            end
            hand_x[0]   <= X_W'(P1_HOME);
            hand_x[1]   <= X_W'(P2_HOME);
            // Alternate who opens each new match.
            attacker    <= ~opening;
            opening     <= ~opening;
            screen      <= SCR_PLAY;
            mode        <= M_PLAY;
            controls_en <= 1'b1;
          end
        end
        default: mode <= M_PLAY;
      endcase
    end
  end

  assign p1_x     = hand_x[0];
  assign p2_x     = hand_x[1];
  assign p1_score = score[0];
  assign p2_score = score[1];
  assign p1_pen   = pen[0];
  assign p2_pen   = pen[1];

endmodule

// File: tb/tb_slap_match_ctrl.sv
// Directed bench for slap_match_ctrl: default-parameter instance plus a small
// instance (short travel/hold, low limits) driven by the same stimulus.
module tb_slap_match_ctrl;

  logic clk = 1'b0;
  logic resetn, tick, btn_p1, btn_p2, btn_restart;

  logic [7:0] p1_x, p2_x, b_p1_x, b_p2_x;
  logic [3:0] p1_score, p2_score, b_p1_score, b_p2_score;
  logic [1:0] p1_pen, p2_pen, b_p1_pen, b_p2_pen;
  logic       attacker, controls_en, b_attacker, b_controls_en;
  logic [2:0] screen, b_screen;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slap_match_ctrl dut (
    .clk(clk), .resetn(resetn), .tick(tick), .btn_p1(btn_p1), .btn_p2(btn_p2),
    .btn_restart(btn_restart), .p1_x(p1_x), .p2_x(p2_x), .p1_score(p1_score),
    .p2_score(p2_score), .p1_pen(p1_pen), .p2_pen(p2_pen), .attacker(attacker),
    .screen(screen), .controls_en(controls_en)
  );

  slap_match_ctrl #(
    .WIN_SCORE(3), .PEN_LIMIT(2), .TRAVEL(8), .HOLD_TICKS(4), .P1_HOME(35), .P2_HOME(41)
  ) dut_b (
    .clk(clk), .resetn(resetn), .tick(tick), .btn_p1(btn_p1), .btn_p2(btn_p2),
    .btn_restart(btn_restart), .p1_x(b_p1_x), .p2_x(b_p2_x), .p1_score(b_p1_score),
    .p2_score(b_p2_score), .p1_pen(b_p1_pen), .p2_pen(b_p2_pen), .attacker(b_attacker),
    .screen(b_screen), .controls_en(b_controls_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Each tick is followed by one idle clock, which is where hit detection lands.
  task automatic ticks(input int n);
    repeat (n) begin
      do_tick();
      step();
    end
  endtask

  task automatic press(input logic b1, input logic b2, input logic br);
    btn_p1 = b1; btn_p2 = b2; btn_restart = br;
    step();
    btn_p1 = 1'b0; btn_p2 = 1'b0; btn_restart = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_p1x"}, p1_x, 35);
    check({tag, "_p2x"}, p2_x, 61);
    check({tag, "_scores"}, {p1_score, p2_score}, 0);
    check({tag, "_pens"}, {p1_pen, p2_pen}, 0);
    check({tag, "_att"}, attacker, 0);
    check({tag, "_scr"}, screen, 0);
    check({tag, "_ctl"}, controls_en, 1);
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; btn_p1 = 1'b0; btn_p2 = 1'b0; btn_restart = 1'b0;
    do_reset();
    check_reset_state("rst");

    // 1: single P1 attack lands on tick 26
    press(1, 0, 0);
    ticks(25);
    check("t1_x25", p1_x, 60);
    do_tick();
    check("t1_x26", p1_x, 61);
    check("t1_score_pre", p1_score, 0);
    step();
    check("t1_score", p1_score, 1);
    check("t1_scr", screen, 1);
    check("t1_ctl", controls_en, 0);
    ticks(349);
    check("t1_hold349", screen, 1);
    ticks(1);
    check("t1_scr_end", screen, 0);
    check("t1_p1home", p1_x, 35);
    check("t1_p2home", p2_x, 61);
    check("t1_ctl_end", controls_en, 1);

    // 2: simultaneous attack + dodge misses; attacker flips at turnaround
    press(1, 1, 0);
    ticks(28);
    check("t2_att_pre", attacker, 0);
    do_tick();
    check("t2_att", attacker, 1);
    check("t2_pens", {p1_pen, p2_pen}, 0);
    check("t2_p1x", p1_x, 64);
    check("t2_p2x", p2_x, 90);
    check("t2_score", p1_score, 1);
    step();
    ticks(29);
    check("t2_p1back", p1_x, 35);
    check("t2_p2back", p2_x, 61);

    // 3: three P2 dodges with P1 idle -> free hit for P1
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      press(0, 1, 0);
      ticks(29);
      check($sformatf("t3_pen%0d", k), p2_pen, k);
      if (k < 3) begin
        check($sformatf("t3_p2x%0d", k), p2_x, 90);
        ticks(29);
        check($sformatf("t3_home%0d", k), p2_x, 61);
      end
    end
    check("t3_score", p1_score, 1);
    check("t3_scr", screen, 3);
    check("t3_ctl", controls_en, 0);
    ticks(350);
    check("t3_scr_end", screen, 0);
    check("t3_pens_end", {p1_pen, p2_pen}, 0);
    check("t3_p2home", p2_x, 61);

    // 4: five P1 hits win the match; restart flips opening attacker
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      press(1, 0, 0);
      ticks(26);
      check($sformatf("t4_score%0d", k), p1_score, k);
      ticks(350);
    end
    check("t4_win", screen, 5);
    check("t4_ctl", controls_en, 0);
    press(1, 1, 0);
    ticks(3);
    check("t4_ign_p1x", p1_x, 35);
    check("t4_ign_p2x", p2_x, 61);
    check("t4_ign_scr", screen, 5);
    press(0, 0, 1);
    check("t4_rst_scores", {p1_score, p2_score}, 0);
    check("t4_rst_att", attacker, 1);
    check("t4_rst_scr", screen, 0);
    check("t4_rst_ctl", controls_en, 1);

    // 5: reset mid-stroke (P2 attacking toward P1)
    press(0, 1, 0);
    ticks(10);
    check("t5_p2x_mid", p2_x, 51);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_reset_state("t5");
    ticks(3);
    check("t5_idle", p2_x, 61);

    // 6: small-parameter instance
    do_reset();
    press(1, 0, 0);
    ticks(6);
    check("t6_hit1", b_p1_score, 1);
    check("t6_hit1_scr", b_screen, 1);
    check("t6_hit1_ctl", b_controls_en, 0);
    ticks(4);
    check("t6_hold_end", b_screen, 0);
    check("t6_p1home", b_p1_x, 35);
    press(0, 1, 0);
    ticks(8);
    check("t6_pen1", b_p2_pen, 1);
    check("t6_p2x_out", b_p2_x, 49);
    ticks(8);
    press(0, 1, 0);
    ticks(8);
    check("t6_pen2", b_p2_pen, 2);
    check("t6_free_score", b_p1_score, 2);
    check("t6_free_scr", b_screen, 3);
    ticks(4);
    check("t6_free_end", b_screen, 0);
    check("t6_pens_end", {b_p1_pen, b_p2_pen}, 0);
    press(1, 0, 0);
    ticks(6);
    check("t6_hit3", b_p1_score, 3);
    ticks(4);
    check("t6_win", b_screen, 5);
    check("t6_win_ctl", b_controls_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
